// File: rtl/instr_fetch_pkg.sv
// Shared types and default parameters for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package instr_fetch_pkg;

    // Default widths and the boot address
    localparam int unsigned DEF_INST_SIZE  = 32;
    localparam int unsigned DEF_ADDR_SIZE  = 32;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEF_FIFO_DEPTH = 2;

    // addi x0, x0, 0 -- downstream stages use it to insert bubbles
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch control states
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } t_fetch_state;

endpackage : instr_fetch_pkg

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from registered storage.
// Latency: data pushed on edge N is visible at the head on cycle N+1.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle; pop when empty is ignored.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Circular pointer advance that also works for non power-of-two depths
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full     = (count_q == CW'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;
    assign o_head_dat = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so push-on-full with pop is accepted
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    // Next-state for storage, pointers and occupancy; flush wins over everything
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers; storage is cleared so the head reads zero out of reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : fetch_fifo

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, req/gnt/rvalid memory requests, instruction buffer towards decode, redirect with discard.
// Latency: zero-wait memory gives request on cycle N -> o_valid on cycle N+2; 1 instr/cycle sustained.
// Backpressure: requests only issue while outstanding + buffered (minus this cycle's dequeue) < FIFO_DEPTH.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned          INST_SIZE  = DEF_INST_SIZE,
    parameter int unsigned          ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter logic [ADDR_SIZE-1:0] RESET_PC   = ADDR_SIZE'(DEF_RESET_PC),
    parameter int unsigned          FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic                 o_imem_req,
    output logic [ADDR_SIZE-1:0] o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvalid,
    input  logic [INST_SIZE-1:0] i_imem_rdata,
    input  logic                 i_redirect,
    input  logic [ADDR_SIZE-1:0] i_redirect_pc,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [INST_SIZE-1:0] o_instr,
    output logic [ADDR_SIZE-1:0] o_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = INST_SIZE + ADDR_SIZE;

    t_fetch_state         state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    logic [CW-1:0]        discard_q, discard_d;

    // Tag queue: one PC per outstanding request, so its count is the outstanding count
    logic [ADDR_SIZE-1:0] tag_head;
    logic [CW-1:0]        tag_count;
    logic                 tag_full;
    logic                 tag_empty;

    // Instruction buffer towards decode
    logic [DW-1:0]        dat_head;
    logic [CW-1:0]        dat_count;
    logic                 dat_full;
    logic                 dat_empty;

    logic                 grant;
    logic                 deq;
    logic                 rsp_keep;
    logic                 credit_ok;
    logic [CW:0]          in_use;
    logic [CW:0]          credit_lim;
    logic [CW-1:0]        outstanding_nxt;

    assign grant    = o_imem_req & i_imem_gnt;
    assign deq      = o_valid & i_ready;
    assign rsp_keep = i_imem_rvalid & (discard_q == '0);

    // Every in-flight request owns a buffer slot, so a response can never land in a full buffer
    assign in_use     = {1'b0, tag_count} + {1'b0, dat_count};
    assign credit_lim = (CW + 1)'(FIFO_DEPTH) + {{CW{1'b0}}, deq};
    assign credit_ok  = (in_use < credit_lim);

    // Outstanding count as it will be after this cycle's grant and response
    assign outstanding_nxt = tag_count + CW'(grant) - CW'(i_imem_rvalid);

    // PC and discard bookkeeping; a redirect overrides grant/response updates
    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (grant) begin
            pc_d = pc_q + ADDR_SIZE'(4);
        end
        if (i_imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
        if (i_redirect) begin
            pc_d      = {i_redirect_pc[ADDR_SIZE-1:2], 2'b00};
            discard_d = outstanding_nxt;
        end
    end

    // Next state: one idle cycle after reset, drain while stale responses remain
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: if (i_redirect && (discard_d != '0)) state_d = S_DRAIN;
            S_DRAIN: if (discard_d == '0) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
    end

    // Memory request outputs; no request in boot or in a redirect cycle
    always_comb begin
        o_imem_req  = 1'b0;
        o_imem_addr = pc_q;
        if ((state_q != S_BOOT) && !i_redirect && credit_ok) begin
            o_imem_req = 1'b1;
        end
    end

    // Decode-side outputs come straight from the buffer head
    always_comb begin
        o_valid          = !dat_empty;
        {o_instr, o_pc}  = dat_head;
    end

    // State, PC and discard registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    // PC of each request, pushed on grant and popped by its (possibly discarded) response
    fetch_fifo #(
        .WIDTH (ADDR_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (1'b0),
        .i_push     (grant),
        .i_push_dat (pc_q),
        .i_pop      (i_imem_rvalid),
        .o_head_dat (tag_head),
        .o_count    (tag_count),
        .o_full     (tag_full),
        .o_empty    (tag_empty)
    );

    // {instr, pc} buffer; a redirect flushes it, including any response landing that cycle
    fetch_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_dat_q (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (i_redirect),
        .i_push     (rsp_keep),
        .i_push_dat ({i_imem_rdata, tag_head}),
        .i_pop      (deq),
        .o_head_dat (dat_head),
        .o_count    (dat_count),
        .o_full     (dat_full),
        .o_empty    (dat_empty)
    );

    // Memory protocol checks: no response without a request, no response into a full buffer
    a_rsp_has_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rvalid |-> !tag_empty);
    a_rsp_has_room: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (rsp_keep && !i_redirect) |-> (!dat_full || deq));
    a_tag_has_room: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        grant |-> (!tag_full || i_imem_rvalid));

endmodule : instr_fetch
